pipe_stage_skid: RTL and testbench

- Parametrised successor to the per-field flop-chain stage registers (ID/EX and peers). One instance carries a whole packed stage bundle of DATA_WIDTH bits.
- Replaces stall_current_stage/stall_next_stage with a valid/ready handshake and a 2-entry skid buffer, so in_ready is driven from a flop and backpressure never forms a combinational path across stages.
- Also provides synchronous flush, occupancy status, and an optional backpressure perf counter.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 tb/tb_pipe_stage_skid.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush and occupancy status.
// Optional backpressure counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [PERF_WIDTH-1:0] perf_stall_cycles
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  push, pop;

  // in_ready comes straight from the skid flop, so backpressure never chains combinationally.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign push = in_valid & ~skid_valid_q;
  assign pop  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (push) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        2'b10: begin
          if (pop && push) begin
            main_data_d = in_data;
          end else if (pop) begin
            main_valid_d = 1'b0;
          end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end
        end
        2'b11: begin
          if (pop) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // (0,1) cannot be reached; hold.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_WIDTH-1:0] perf_q, perf_d;

  // Saturating count of cycles the head is stalled by downstream; flush leaves it alone.
  always_comb begin
    perf_d = perf_q;
    if (main_valid_q && !out_ready && (perf_q != {PERF_WIDTH{1'b1}})) begin
      perf_d = perf_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int PW = 4;
  localparam int PERF_MAX = 15;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [PW-1:0] perf_stall_cycles;

  int tests = 0;
  int fails = 0;

  pipe_stage_skid #(.DATA_WIDTH(DW), .PERF_WIDTH(PW)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .occupancy        (occupancy),
    .perf_stall_cycles(perf_stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 whose acceptance is decided by the
  // occupancy before the edge; the visible head keeps its last value once drained.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  int            m_perf;
  bit            m_pop, m_push, model_ok;

  initial begin
    model_ok = 1'b0;
    m_data   = '0;
    m_perf   = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_data = '0;
      m_perf = 0;
    end else begin
`ifdef PIPE_STAGE_PERF_EN
      if (mq.size() > 0 && !out_ready && m_perf < PERF_MAX) m_perf++;
`endif
      if (flush) begin
        mq.delete();
        m_data = '0;
      end else begin
        m_pop  = (mq.size() > 0) && out_ready;
        m_push = in_valid && (mq.size() < 2);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(in_data);
        if (mq.size() > 0) m_data = mq[0];
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("m_out_data", 64'(out_data), 64'(m_data));
      chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
      chk("m_perf", 64'(perf_stall_cycles), 64'(m_perf));
      chk("no_skid_without_main", 64'(!in_ready && !out_valid), 64'(0));
    end
  end

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;

    // Reset while upstream is offering data
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    chk("first_push_valid", 64'(out_valid), 64'd1);
    chk("first_push_data", 64'(out_data), 64'h11);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_keeps_data", 64'(out_data), 64'h11);

    // Streaming at one bundle per cycle
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1, DW'(i), 1'b1);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream_empty", 64'(occupancy), 64'd0);

    // Skid absorb and release
    step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    chk("skid_occ", 64'(occupancy), 64'd2);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_head", 64'(out_data), 64'hA);
    step(1'b1, 1'b0, 1'b1, 32'hEE, 1'b0);
    chk("skid_hold", 64'(out_data), 64'hA);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("skid_pop1_data", 64'(out_data), 64'hB);
    chk("skid_pop1_ready", 64'(in_ready), 64'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("skid_pop2_valid", 64'(out_valid), 64'd0);

    // Flush with a concurrent push
    step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_data", 64'(out_data), 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush_no_c", 64'(out_valid), 64'd0);

    // Reset beats flush
    step(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h6, 1'b0);
    chk("prio_occ", 64'(occupancy), 64'd0);
    chk("prio_ready", 64'(in_ready), 64'd1);
    chk("prio_perf", 64'(perf_stall_cycles), 64'd0);

    // Backpressure counter, saturation, and flush not clearing it
    step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_10", 64'(perf_stall_cycles), 64'd10);
`else
    chk("perf_off_10", 64'(perf_stall_cycles), 64'd0);
`endif
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_sat", 64'(perf_stall_cycles), 64'd15);
`else
    chk("perf_off_20", 64'(perf_stall_cycles), 64'd0);
`endif

    // Mixed traffic pattern, checked by the model only
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i == 25), (i % 4 != 3), DW'(i * 32'h1111), (i % 3 != 0));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("final_empty", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
